// File: rtl/msx_sdram_arbiter.sv
// rtl/msx_sdram_arbiter.sv - single-port SDRAM arbiter for dl / cpu / bg requesters
// Optional WAIT timeout is enabled by defining SDRAM_ARB_TIMEOUT_EN.
module msx_sdram_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int CPU_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_req,
  input  logic              cpu_req,
  input  logic              bg_req,
  input  logic              dl_we,
  input  logic              cpu_we,
  input  logic              bg_we,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] bg_addr,
  input  logic [7:0]        dl_din,
  input  logic [7:0]        cpu_din,
  input  logic [7:0]        bg_din,
  output logic              dl_ack,
  output logic              cpu_ack,
  output logic              bg_ack,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [7:0]        sdram_din,
  output logic              sdram_rd,
  output logic              sdram_we,
  input  logic              sdram_ready,
  input  logic [7:0]        sdram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] G_DL  = 2'd0;
  localparam logic [1:0] G_CPU = 2'd1;
  localparam logic [1:0] G_BG  = 2'd2;
  localparam logic [3:0] BURST_MAX = 4'(CPU_BURST);

  if (CPU_BURST < 1 || CPU_BURST > 15 || TIMEOUT < 1) begin : g_bad_cfg
    $error("msx_sdram_arbiter: CPU_BURST must be 1..15 and TIMEOUT >= 1");
  end

  state_t            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              wr_q, wr_d;
  logic [3:0]        burst_q, burst_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [2:0]        ack_q, ack_d;
  logic              str_rd_q, str_rd_d;
  logic              str_we_q, str_we_d;
  logic              busy_q, busy_d;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    din_d     = din_q;
    wr_d      = wr_q;
    burst_d   = burst_q;
    rd_data_d = rd_data_q;
    ack_d     = 3'b000;
    str_rd_d  = 1'b0;
    str_we_d  = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    to_d      = to_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (dl_req || cpu_req || bg_req) begin
          state_d = S_ISSUE;
          if (dl_req) begin
            gnt_d  = G_DL;
            addr_d = dl_addr;
            din_d  = dl_din;
            wr_d   = dl_we;
            if (!bg_req) burst_d = '0;
          end else if (cpu_req && !(bg_req && burst_q == BURST_MAX)) begin
            gnt_d  = G_CPU;
            addr_d = cpu_addr;
            din_d  = cpu_din;
            wr_d   = cpu_we;
            // Count only cpu grants that make a waiting bg wait longer.
            if (!bg_req)                    burst_d = '0;
            else if (burst_q != BURST_MAX)  burst_d = burst_q + 4'd1;
          end else begin
            gnt_d   = G_BG;
            addr_d  = bg_addr;
            din_d   = bg_din;
            wr_d    = bg_we;
            burst_d = '0;
          end
          str_rd_d = !wr_d;
          str_we_d = wr_d;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      S_WAIT: begin
        if (sdram_ready) begin
          state_d = S_DONE;
          ack_d   = 3'b001 << gnt_q;
          if (!wr_q) rd_data_d = sdram_dout;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (to_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = S_DONE;
          ack_d     = 3'b001 << gnt_q;
          rd_data_d = 8'hFF;
          err_d     = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= G_DL;
      addr_q    <= '0;
      din_q     <= '0;
      wr_q      <= 1'b0;
      burst_q   <= '0;
      rd_data_q <= '0;
      ack_q     <= '0;
      str_rd_q  <= 1'b0;
      str_we_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      to_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      wr_q      <= wr_d;
      burst_q   <= burst_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      str_rd_q  <= str_rd_d;
      str_we_q  <= str_we_d;
      busy_q    <= busy_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
      to_q      <= to_d;
      err_q     <= err_d;
`endif
    end
  end

  assign dl_ack     = ack_q[0];
  assign cpu_ack    = ack_q[1];
  assign bg_ack     = ack_q[2];
  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign sdram_addr = addr_q;
  assign sdram_din  = din_q;
  assign sdram_rd   = str_rd_q;
  assign sdram_we   = str_we_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_msx_sdram_arbiter.sv
// tb/tb_msx_sdram_arbiter.sv - self-checking bench for msx_sdram_arbiter
module tb_msx_sdram_arbiter;
  localparam int ADDR_W    = 25;
  localparam int CPU_BURST = 4;
  localparam int TIMEOUT   = 255;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        req, we;
  logic [ADDR_W-1:0] addr [3];
  logic [7:0]        din  [3];
  logic              dl_ack, cpu_ack, bg_ack, busy, err, sdram_rd, sdram_we;
  logic [7:0]        rd_data, sdram_din;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_ready;
  logic [7:0]        sdram_dout;
  logic [2:0]        ackv;

  assign ackv = {bg_ack, cpu_ack, dl_ack};

  msx_sdram_arbiter #(.ADDR_W(ADDR_W), .CPU_BURST(CPU_BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .dl_req(req[0]), .cpu_req(req[1]), .bg_req(req[2]),
    .dl_we(we[0]), .cpu_we(we[1]), .bg_we(we[2]),
    .dl_addr(addr[0]), .cpu_addr(addr[1]), .bg_addr(addr[2]),
    .dl_din(din[0]), .cpu_din(din[1]), .bg_din(din[2]),
    .dl_ack(dl_ack), .cpu_ack(cpu_ack), .bg_ack(bg_ack),
    .rd_data(rd_data), .busy(busy), .err(err),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din),
    .sdram_rd(sdram_rd), .sdram_we(sdram_we),
    .sdram_ready(sdram_ready), .sdram_dout(sdram_dout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [7:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; we = '0; sdram_ready = 1'b0; sdram_dout = '0;
    tick(); tick();
    chk("reset outs", 32'({ackv, busy, err, sdram_rd, sdram_we}), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    chk("reset sdram_addr", 32'(sdram_addr), 32'd0);
    chk("reset sdram_din", 32'(sdram_din), 32'd0);
    reset_n = 1'b1;
    last_rd = 8'h00;
  endtask

  // Waits for a strobe, answers it one cycle later with a random byte, returns the acked requester.
  task automatic serve(output int owner, output int s_cyc);
    logic [7:0] d;
    owner = -1;
    s_cyc = cyc;
    for (int k = 0; k < 20 && !(sdram_rd || sdram_we); k++) tick();
    chk("serve strobe seen", 32'(sdram_rd | sdram_we), 32'd1);
    if (!(sdram_rd || sdram_we)) return;
    s_cyc = cyc;
    tick();
    d = 8'($urandom_range(1, 255));
    sdram_ready = 1'b1; sdram_dout = d;
    tick();
    sdram_ready = 1'b0;
    owner = (ackv == 3'b001) ? 0 : (ackv == 3'b010) ? 1 : (ackv == 3'b100) ? 2 : -1;
    chk("serve rd_data", 32'(rd_data), 32'(d));
    last_rd = d;
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] we;
    logic [7:0] dout;
    int         owner;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vt [9];

  task automatic run_vec(input int i);
    int o;
    o = vt[i].owner;
    addr[0] = ADDR_W'(32'h0100000 + i);
    addr[1] = (i == 0) ? 25'h0001234 : ADDR_W'(32'h0002000 + i);
    addr[2] = ADDR_W'(32'h1000000 + i);
    for (int k = 0; k < 3; k++) din[k] = 8'(8'h40 * k + i);
    we = vt[i].we; req = vt[i].req;
    tick();
    chk($sformatf("vec%0d strobe", i), 32'({sdram_rd, sdram_we}), vt[i].we[o] ? 32'd1 : 32'd2);
    chk($sformatf("vec%0d addr", i), 32'(sdram_addr), 32'(addr[o]));
    chk($sformatf("vec%0d din", i), 32'(sdram_din), 32'(din[o]));
    chk($sformatf("vec%0d busy", i), 32'(busy), 32'd1);
    tick();
    chk($sformatf("vec%0d early ack", i), 32'({ackv, sdram_rd, sdram_we}), 32'd0);
    sdram_ready = 1'b1; sdram_dout = vt[i].dout;
    tick();
    sdram_ready = 1'b0;
    chk($sformatf("vec%0d ack", i), 32'(ackv), 32'(3'b001 << o));
    chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vt[i].exp_rd));
    req = '0;
    tick();
    chk($sformatf("vec%0d idle", i), 32'({ackv, busy}), 32'd0);
  endtask

  // Random-phase reference state (transaction level)
  logic [2:0]        rq_prev, we_prev;
  logic [ADDR_W-1:0] ad_prev [3];
  logic [7:0]        dn_prev [3];
  bit                outst, in_done, ack_due, idle_prev, issue_now, exp_busy;
  int                owner_m, cnt_m, w, gap [3];
  logic [ADDR_W-1:0] lat_a;
  logic [7:0]        lat_d, exp_rd, pend_rd;
  logic              lat_w;
  logic [2:0]        exp_ack;
  logic [1:0]        exp_str;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int o, s, s_prev, n_ack, n_str, d;
    vt[0] = '{3'b010, 3'b000, 8'h5A, 1, 8'h5A};
    vt[1] = '{3'b111, 3'b000, 8'h11, 0, 8'h11};
    vt[2] = '{3'b110, 3'b000, 8'h22, 1, 8'h22};
    vt[3] = '{3'b100, 3'b100, 8'h33, 2, 8'h22};
    vt[4] = '{3'b001, 3'b001, 8'h44, 0, 8'h22};
    vt[5] = '{3'b110, 3'b010, 8'h55, 1, 8'h22};
    vt[6] = '{3'b101, 3'b000, 8'h66, 0, 8'h66};
    vt[7] = '{3'b010, 3'b000, 8'h77, 1, 8'h77};
    vt[8] = '{3'b100, 3'b000, 8'h88, 2, 8'h88};
    for (int k = 0; k < 3; k++) begin addr[k] = '0; din[k] = '0; end

    do_reset();
    for (int i = 0; i < 9; i++) run_vec(i);

    // cpu and bg held: cpu x CPU_BURST then bg, with 4-cycle issue spacing
    do_reset();
    we = '0; req = 3'b110;
    s_prev = -1;
    for (int k = 0; k < 10; k++) begin
      serve(o, s);
      chk($sformatf("burst grant %0d", k), 32'(o), (k % 5 == 4) ? 32'd2 : 32'd1);
      if (s_prev >= 0) chk($sformatf("burst spacing %0d", k), 32'(s - s_prev), 32'd4);
      s_prev = s;
    end
    req = '0; tick();

    // dl wins while held, then cpu
    do_reset();
    we = '0; req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      serve(o, s);
      chk($sformatf("dl prio %0d", k), 32'(o), 32'd0);
    end
    req[0] = 1'b0;
    serve(o, s);
    chk("cpu after dl", 32'(o), 32'd1);
    req = '0; tick(); tick();

    // bg write with inputs changing and request dropped mid-transaction
    addr[2] = 25'h1FFFFFF; din[2] = 8'hC3; we = 3'b100; req = 3'b100;
    tick();
    chk("bgw strobe", 32'({sdram_rd, sdram_we}), 32'd1);
    sdram_ready = 1'b1; sdram_dout = 8'hEE;
    addr[2] = 25'h0000000; din[2] = 8'h00; req = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      sdram_ready = 1'b0;
      chk($sformatf("bgw addr hold %0d", k), 32'(sdram_addr), 32'h1FFFFFF);
      chk($sformatf("bgw din hold %0d", k), 32'(sdram_din), 32'hC3);
      chk($sformatf("bgw no ack %0d", k), 32'({ackv, sdram_rd, sdram_we}), 32'd0);
    end
    sdram_ready = 1'b1;
    tick();
    sdram_ready = 1'b0;
    chk("bgw ack", 32'(ackv), 32'd4);
    chk("bgw rd_data kept", 32'(rd_data), 32'(last_rd));
    chk("bgw addr at done", 32'(sdram_addr), 32'h1FFFFFF);
    n_ack = 0; n_str = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_ack += int'(ackv != 0); n_str += int'(sdram_rd | sdram_we);
    end
    chk("bgw single ack", 32'(n_ack), 32'd0);
    chk("bgw no reissue", 32'(n_str), 32'd0);

    // reset during WAIT of a cpu read
    addr[1] = 25'h0000055; we = '0; req = 3'b010;
    tick();
    chk("rstw strobe", 32'({sdram_rd, sdram_we}), 32'd2);
    tick();
    reset_n = 1'b0; req = '0;
    tick();
    reset_n = 1'b1;
    chk("rstw outs", 32'({ackv, busy, err, sdram_rd, sdram_we}), 32'd0);
    chk("rstw rd_data", 32'(rd_data), 32'd0);
    chk("rstw sdram_addr", 32'(sdram_addr), 32'd0);
    sdram_ready = 1'b1; sdram_dout = 8'h99;
    n_ack = 0; n_str = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      sdram_ready = 1'b0;
      n_ack += int'(ackv != 0); n_str += int'(sdram_rd | sdram_we);
    end
    chk("rstw no ack", 32'(n_ack), 32'd0);
    chk("rstw no strobe", 32'(n_str), 32'd0);
    req = 3'b010;
    serve(o, s);
    chk("rstw new cpu", 32'(o), 32'd1);
    req = '0; tick(); tick();

`ifdef SDRAM_ARB_TIMEOUT_EN
    req = 3'b010; we = '0;
    for (int k = 0; k < 20 && !sdram_rd; k++) tick();
    chk("to strobe", 32'(sdram_rd), 32'd1);
    s = cyc; req = '0;
    for (int k = 0; k < 400 && ackv == 0; k++) tick();
    d = cyc - s;
    chk("to ack", 32'(ackv), 32'd2);
    chk("to latency 255..257", 32'(d >= 255 && d <= 257), 32'd1);
    chk("to rd_data", 32'(rd_data), 32'hFF);
    chk("to err", 32'(err), 32'd1);
    req = 3'b010;
    serve(o, s);
    chk("to next owner", 32'(o), 32'd1);
    chk("to err sticky", 32'(err), 32'd1);
    req = '0; tick();
`endif

    // Randomized traffic against the transaction-level reference
    do_reset();
    outst = 0; in_done = 0; ack_due = 0; idle_prev = 1; cnt_m = 0; owner_m = 0;
    exp_rd = 8'h00; pend_rd = 8'h00; lat_a = '0; lat_d = '0; lat_w = 1'b0;
    rq_prev = '0; we_prev = '0;
    for (int k = 0; k < 3; k++) begin gap[k] = 0; ad_prev[k] = addr[k]; dn_prev[k] = din[k]; end
    for (int t = 0; t < 3000; t++) begin
      tick();
      exp_ack = '0; exp_str = 2'b00; issue_now = 0;
      if (ack_due) begin
        exp_ack = 3'b001 << owner_m;
        ack_due = 0; outst = 0; in_done = 1;
        if (!lat_w) exp_rd = pend_rd;
      end else begin
        in_done = 0;
        if (!outst && idle_prev && rq_prev != 0) begin
          if (rq_prev[0]) begin
            w = 0;
            if (!rq_prev[2]) cnt_m = 0;
          end else if (rq_prev[1] && !(rq_prev[2] && cnt_m >= CPU_BURST)) begin
            w = 1;
            cnt_m = rq_prev[2] ? ((cnt_m + 1 > CPU_BURST) ? CPU_BURST : cnt_m + 1) : 0;
          end else begin
            w = 2; cnt_m = 0;
          end
          owner_m = w; lat_a = ad_prev[w]; lat_d = dn_prev[w]; lat_w = we_prev[w];
          outst = 1; issue_now = 1;
          exp_str = lat_w ? 2'b01 : 2'b10;
        end
      end
      exp_busy = outst || in_done;
      chk("rnd ack", 32'(ackv), 32'(exp_ack));
      chk("rnd strobe", 32'({sdram_rd, sdram_we}), 32'(exp_str));
      chk("rnd busy", 32'(busy), 32'(exp_busy));
      chk("rnd rd_data", 32'(rd_data), 32'(exp_rd));
      chk("rnd err", 32'(err), 32'd0);
      if (exp_busy) begin
        chk("rnd sdram_addr", 32'(sdram_addr), 32'(lat_a));
        chk("rnd sdram_din", 32'(sdram_din), 32'(lat_d));
      end
      idle_prev = !exp_busy;

      for (int k = 0; k < 3; k++) begin
        if (exp_ack[k]) begin
          if (req[k] && $urandom_range(0, 1) == 0) begin
            addr[k] = ADDR_W'($urandom); din[k] = 8'($urandom); we[k] = 1'($urandom);
          end else begin
            req[k] = 1'b0; gap[k] = $urandom_range(0, 3);
          end
        end else if (req[k]) begin
          if (outst && owner_m == k) begin
            if ($urandom_range(0, 3) == 0) begin addr[k] = ADDR_W'($urandom); din[k] = 8'($urandom); end
            if ($urandom_range(0, 9) == 0) begin req[k] = 1'b0; gap[k] = $urandom_range(0, 3); end
          end
        end else if (gap[k] > 0) begin
          gap[k]--;
        end else if ($urandom_range(0, (k == 0) ? 5 : 1) == 0) begin
          req[k] = 1'b1;
          addr[k] = ADDR_W'($urandom); din[k] = 8'($urandom); we[k] = 1'($urandom);
        end
      end
      sdram_ready = ($urandom_range(0, 2) == 0);
      sdram_dout = 8'($urandom);
      if (outst && !issue_now && !ack_due && sdram_ready) begin
        ack_due = 1; pend_rd = sdram_dout;
      end
      rq_prev = req; we_prev = we;
      for (int k = 0; k < 3; k++) begin ad_prev[k] = addr[k]; dn_prev[k] = din[k]; end
    end
    req = '0; sdram_ready = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
